// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed-priority display fetches, CPU accesses fill idle slots.
// All VRAM-facing signals and requester outputs are registered.
module vram_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  video_request,
    input  logic [ADDR_WIDTH-1:0] video_address,
    output logic [DATA_WIDTH-1:0] video_data,
    output logic                  video_valid,
    output logic                  video_overrun,
    input  logic                  cpu_request,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_write_data,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_read_data,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  memory_write_enable,
    output logic [DATA_WIDTH-1:0] memory_write_data,
    input  logic [DATA_WIDTH-1:0] memory_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        VIDEO_READ,
        CPU_READ,
        CPU_WRITE,
        CPU_ACK
    } state_t;

    localparam logic [1:0] LAT = 2'(MEM_LATENCY);

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  video_pending_q, video_pending_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                  video_overrun_q, video_overrun_d;
    logic [DATA_WIDTH-1:0] video_data_q, video_data_d;
    logic                  video_valid_q, video_valid_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic [DATA_WIDTH-1:0] cpu_read_data_q, cpu_read_data_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                  want_video;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic                  video_issue;
    logic                  lat_done;

    // An already-pending fetch is older than a coincident new request, so it wins.
    assign want_video  = video_request | video_pending_q;
    assign eff_addr    = video_pending_q ? pend_addr_q : video_address;
    assign video_issue = (state_q == IDLE) && want_video;
    // Counter is loaded with L at issue and reaches 0 in the cycle the RAM output is valid.
    assign lat_done    = (cnt_q == 2'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (want_video) begin
                    state_d = VIDEO_READ;
                end else if (cpu_request) begin
                    state_d = cpu_write ? CPU_WRITE : CPU_READ;
                end
            end
            VIDEO_READ: if (lat_done) state_d = IDLE;
            CPU_READ:   if (lat_done) state_d = CPU_ACK;
            CPU_WRITE:  state_d = CPU_ACK;
            CPU_ACK:    state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d           = cnt_q;
        mem_addr_d      = mem_addr_q;
        mem_we_d        = 1'b0;
        mem_wdata_d     = mem_wdata_q;
        video_data_d    = video_data_q;
        video_valid_d   = 1'b0;
        cpu_ready_d     = 1'b0;
        cpu_read_data_d = cpu_read_data_q;
        case (state_q)
            IDLE: begin
                if (want_video) begin
                    mem_addr_d = eff_addr;
                    cnt_d      = LAT;
                end else if (cpu_request && cpu_write) begin
                    mem_addr_d  = cpu_address;
                    mem_wdata_d = cpu_write_data;
                    mem_we_d    = 1'b1;
                end else if (cpu_request) begin
                    mem_addr_d = cpu_address;
                    cnt_d      = LAT;
                end
            end
            VIDEO_READ: begin
                if (lat_done) begin
                    video_data_d  = memory_read_data;
                    video_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            CPU_READ: begin
                if (lat_done) begin
                    cpu_read_data_d = memory_read_data;
                    cpu_ready_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            CPU_WRITE: cpu_ready_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        video_pending_d = video_pending_q;
        pend_addr_d     = pend_addr_q;
        video_overrun_d = video_overrun_q;
        if (video_request && video_pending_q) begin
            video_overrun_d = 1'b1;
        end
        if (video_issue) begin
            video_pending_d = 1'b0;
        end else if (video_request && !video_pending_q) begin
            video_pending_d = 1'b1;
            pend_addr_d     = video_address;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q           <= '0;
            video_pending_q <= 1'b0;
            pend_addr_q     <= '0;
            video_overrun_q <= 1'b0;
            video_data_q    <= '0;
            video_valid_q   <= 1'b0;
            cpu_ready_q     <= 1'b0;
            cpu_read_data_q <= '0;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= '0;
        end else begin
            cnt_q           <= cnt_d;
            video_pending_q <= video_pending_d;
            pend_addr_q     <= pend_addr_d;
            video_overrun_q <= video_overrun_d;
            video_data_q    <= video_data_d;
            video_valid_q   <= video_valid_d;
            cpu_ready_q     <= cpu_ready_d;
            cpu_read_data_q <= cpu_read_data_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    assign video_data          = video_data_q;
    assign video_valid         = video_valid_q;
    assign video_overrun       = video_overrun_q;
    assign cpu_ready           = cpu_ready_q;
    assign cpu_read_data       = cpu_read_data_q;
    assign memory_address      = mem_addr_q;
    assign memory_write_enable = mem_we_q;
    assign memory_write_data   = mem_wdata_q;

    a_latency_range: assert property (@(posedge clock)
        (MEM_LATENCY >= 1) && (MEM_LATENCY <= 3));
    a_ready_pulse: assert property (@(posedge clock) disable iff (reset)
        cpu_ready |=> !cpu_ready);
    a_valid_pulse: assert property (@(posedge clock) disable iff (reset)
        video_valid |=> !video_valid);
    a_we_pulse: assert property (@(posedge clock) disable iff (reset)
        memory_write_enable |=> !memory_write_enable);
    a_overrun_sticky: assert property (@(posedge clock) disable iff (reset)
        video_overrun |=> video_overrun);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: instance a with MEM_LATENCY=1, instance b with MEM_LATENCY=3,
// each attached to a behavioural synchronous RAM of matching read latency.
module tb_vram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic       ld_en = 1'b0;
    logic [9:0] ld_addr = '0;
    logic [7:0] ld_data = '0;

    logic       a_reset, a_video_request, a_video_valid, a_video_overrun;
    logic [9:0] a_video_address, a_cpu_address, a_memory_address;
    logic [7:0] a_video_data, a_cpu_write_data, a_cpu_read_data, a_memory_write_data, a_memory_read_data;
    logic       a_cpu_request, a_cpu_write, a_cpu_ready, a_memory_write_enable;

    logic       b_reset, b_video_request, b_video_valid, b_video_overrun;
    logic [9:0] b_video_address, b_cpu_address, b_memory_address;
    logic [7:0] b_video_data, b_cpu_write_data, b_cpu_read_data, b_memory_write_data, b_memory_read_data;
    logic       b_cpu_request, b_cpu_write, b_cpu_ready, b_memory_write_enable;

    vram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .MEM_LATENCY(1)) dut_a (
        .clock(clk), .reset(a_reset),
        .video_request(a_video_request), .video_address(a_video_address),
        .video_data(a_video_data), .video_valid(a_video_valid), .video_overrun(a_video_overrun),
        .cpu_request(a_cpu_request), .cpu_write(a_cpu_write), .cpu_address(a_cpu_address),
        .cpu_write_data(a_cpu_write_data), .cpu_ready(a_cpu_ready), .cpu_read_data(a_cpu_read_data),
        .memory_address(a_memory_address), .memory_write_enable(a_memory_write_enable),
        .memory_write_data(a_memory_write_data), .memory_read_data(a_memory_read_data)
    );

    vram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .MEM_LATENCY(3)) dut_b (
        .clock(clk), .reset(b_reset),
        .video_request(b_video_request), .video_address(b_video_address),
        .video_data(b_video_data), .video_valid(b_video_valid), .video_overrun(b_video_overrun),
        .cpu_request(b_cpu_request), .cpu_write(b_cpu_write), .cpu_address(b_cpu_address),
        .cpu_write_data(b_cpu_write_data), .cpu_ready(b_cpu_ready), .cpu_read_data(b_cpu_read_data),
        .memory_address(b_memory_address), .memory_write_enable(b_memory_write_enable),
        .memory_write_data(b_memory_write_data), .memory_read_data(b_memory_read_data)
    );

    logic [7:0] mem_a [0:1023];
    logic [7:0] mem_b [0:1023];
    logic [7:0] a_rd0;
    logic [7:0] b_rd0, b_rd1, b_rd2;

    always @(posedge clk) begin
        if (ld_en) mem_a[ld_addr] <= ld_data;
        else if (a_memory_write_enable) mem_a[a_memory_address] <= a_memory_write_data;
        a_rd0 <= mem_a[a_memory_address];
    end
    assign a_memory_read_data = a_rd0;

    always @(posedge clk) begin
        if (ld_en) mem_b[ld_addr] <= ld_data;
        else if (b_memory_write_enable) mem_b[b_memory_address] <= b_memory_write_data;
        b_rd0 <= mem_b[b_memory_address];
        b_rd1 <= b_rd0;
        b_rd2 <= b_rd1;
    end
    assign b_memory_read_data = b_rd2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] addr, input logic [7:0] data);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic test_reset;
        logic [37:0] obs_a, obs_b;
        obs_a = {a_video_data, a_video_valid, a_video_overrun, a_cpu_ready, a_cpu_read_data,
                 a_memory_address, a_memory_write_enable, a_memory_write_data};
        obs_b = {b_video_data, b_video_valid, b_video_overrun, b_cpu_ready, b_cpu_read_data,
                 b_memory_address, b_memory_write_enable, b_memory_write_data};
        n_cmp++;
        if (obs_a !== 38'h0) begin n_bad++; $display("FAIL reset_outputs_a: got %h want 0", obs_a); end
        n_cmp++;
        if (obs_b !== 38'h0) begin n_bad++; $display("FAIL reset_outputs_b: got %h want 0", obs_b); end
        a_reset = 1'b0;
        b_reset = 1'b0;
        tick();
        n_cmp++;
        if ({a_video_valid, a_cpu_ready, a_memory_write_enable} !== 3'b000) begin
            n_bad++; $display("FAIL idle_after_reset: got %b want 000",
                              {a_video_valid, a_cpu_ready, a_memory_write_enable});
        end
    endtask

    task automatic test_video_fetch;
        a_video_request = 1'b1; a_video_address = 10'h005;
        tick();
        a_video_request = 1'b0;
        n_cmp++;
        if (a_memory_address !== 10'h005) begin n_bad++; $display("FAIL vid_addr_c1: got %h want 005", a_memory_address); end
        n_cmp++;
        if (a_video_valid !== 1'b0) begin n_bad++; $display("FAIL vid_valid_c1: got %b want 0", a_video_valid); end
        tick();
        n_cmp++;
        if (a_video_valid !== 1'b0) begin n_bad++; $display("FAIL vid_valid_c2: got %b want 0", a_video_valid); end
        tick();
        n_cmp++;
        if ({a_video_valid, a_video_data} !== {1'b1, 8'h41}) begin
            n_bad++; $display("FAIL vid_c3: got valid=%b data=%h want valid=1 data=41", a_video_valid, a_video_data);
        end
        tick();
        n_cmp++;
        if ({a_video_valid, a_video_data} !== {1'b0, 8'h41}) begin
            n_bad++; $display("FAIL vid_hold_c4: got valid=%b data=%h want valid=0 data=41", a_video_valid, a_video_data);
        end
    endtask

    task automatic test_cpu_write;
        a_cpu_request = 1'b1; a_cpu_write = 1'b1; a_cpu_address = 10'h3BF; a_cpu_write_data = 8'h7E;
        tick();
        n_cmp++;
        if ({a_memory_write_enable, a_memory_address, a_memory_write_data, a_cpu_ready} !== {1'b1, 10'h3BF, 8'h7E, 1'b0}) begin
            n_bad++; $display("FAIL wr_c1: got we=%b addr=%h data=%h rdy=%b want we=1 addr=3bf data=7e rdy=0",
                              a_memory_write_enable, a_memory_address, a_memory_write_data, a_cpu_ready);
        end
        tick();
        n_cmp++;
        if ({a_memory_write_enable, a_cpu_ready} !== 2'b01) begin
            n_bad++; $display("FAIL wr_c2: got we=%b rdy=%b want we=0 rdy=1", a_memory_write_enable, a_cpu_ready);
        end
        tick();
        a_cpu_request = 1'b0; a_cpu_write = 1'b0;
        n_cmp++;
        if ({a_memory_write_enable, a_cpu_ready} !== 2'b00) begin
            n_bad++; $display("FAIL wr_c3: got we=%b rdy=%b want 0 0", a_memory_write_enable, a_cpu_ready);
        end
        tick();
        n_cmp++;
        if ({a_memory_write_enable, a_cpu_ready} !== 2'b00) begin
            n_bad++; $display("FAIL wr_c4_no_second: got we=%b rdy=%b want 0 0", a_memory_write_enable, a_cpu_ready);
        end
        n_cmp++;
        if (mem_a[10'h3BF] !== 8'h7E) begin n_bad++; $display("FAIL wr_stored: got %h want 7e", mem_a[10'h3BF]); end
    endtask

    task automatic test_simultaneous;
        a_video_request = 1'b1; a_video_address = 10'h010;
        a_cpu_request = 1'b1; a_cpu_write = 1'b0; a_cpu_address = 10'h020;
        tick();
        a_video_request = 1'b0;
        n_cmp++;
        if (a_memory_address !== 10'h010) begin n_bad++; $display("FAIL sim_addr_c1: got %h want 010", a_memory_address); end
        tick();
        tick();
        n_cmp++;
        if ({a_video_valid, a_video_data, a_cpu_ready} !== {1'b1, 8'hA5, 1'b0}) begin
            n_bad++; $display("FAIL sim_c3: got valid=%b data=%h rdy=%b want 1 a5 0", a_video_valid, a_video_data, a_cpu_ready);
        end
        tick();
        n_cmp++;
        if (a_memory_address !== 10'h020) begin n_bad++; $display("FAIL sim_addr_c4: got %h want 020", a_memory_address); end
        tick();
        n_cmp++;
        if (a_cpu_ready !== 1'b0) begin n_bad++; $display("FAIL sim_rdy_c5: got %b want 0", a_cpu_ready); end
        tick();
        n_cmp++;
        if ({a_cpu_ready, a_cpu_read_data} !== {1'b1, 8'h3C}) begin
            n_bad++; $display("FAIL sim_c6: got rdy=%b data=%h want 1 3c", a_cpu_ready, a_cpu_read_data);
        end
        tick();
        a_cpu_request = 1'b0;
        n_cmp++;
        if (a_cpu_ready !== 1'b0) begin n_bad++; $display("FAIL sim_rdy_c7: got %b want 0", a_cpu_ready); end
    endtask

    task automatic test_pending;
        a_cpu_request = 1'b1; a_cpu_write = 1'b0; a_cpu_address = 10'h040;
        tick();
        a_video_request = 1'b1; a_video_address = 10'h011;
        tick();
        a_video_request = 1'b0;
        tick();
        n_cmp++;
        if ({a_cpu_ready, a_cpu_read_data} !== {1'b1, 8'h99}) begin
            n_bad++; $display("FAIL pend_cpu_c3: got rdy=%b data=%h want 1 99", a_cpu_ready, a_cpu_read_data);
        end
        tick();
        a_cpu_request = 1'b0;
        tick();
        n_cmp++;
        if (a_memory_address !== 10'h011) begin n_bad++; $display("FAIL pend_addr_c5: got %h want 011", a_memory_address); end
        tick();
        tick();
        n_cmp++;
        if ({a_video_valid, a_video_data, a_video_overrun} !== {1'b1, 8'h77, 1'b0}) begin
            n_bad++; $display("FAIL pend_c7: got valid=%b data=%h ovr=%b want 1 77 0", a_video_valid, a_video_data, a_video_overrun);
        end
    endtask

    task automatic test_overrun;
        int valid_cnt;
        logic saw_002;
        valid_cnt = 0;
        saw_002 = 1'b0;
        a_cpu_request = 1'b1; a_cpu_write = 1'b0; a_cpu_address = 10'h040;
        tick();
        a_video_request = 1'b1; a_video_address = 10'h001;
        tick();
        a_video_address = 10'h002;
        tick();
        a_video_request = 1'b0;
        n_cmp++;
        if ({a_video_overrun, a_cpu_ready} !== 2'b11) begin
            n_bad++; $display("FAIL ovr_c3: got ovr=%b rdy=%b want 1 1", a_video_overrun, a_cpu_ready);
        end
        tick();
        a_cpu_request = 1'b0;
        for (int c = 5; c <= 14; c++) begin
            tick();
            if (a_memory_address === 10'h002) saw_002 = 1'b1;
            if (a_video_valid === 1'b1) begin
                valid_cnt++;
                n_cmp++;
                if (a_video_data !== 8'h11) begin n_bad++; $display("FAIL ovr_data: got %h want 11", a_video_data); end
            end
            if (c == 5) begin
                n_cmp++;
                if (a_memory_address !== 10'h001) begin n_bad++; $display("FAIL ovr_addr_c5: got %h want 001", a_memory_address); end
            end
        end
        n_cmp++;
        if (valid_cnt !== 1) begin n_bad++; $display("FAIL ovr_valid_count: got %0d want 1", valid_cnt); end
        n_cmp++;
        if (saw_002 !== 1'b0) begin n_bad++; $display("FAIL ovr_dropped_fetched: got %b want 0", saw_002); end
        n_cmp++;
        if (a_video_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", a_video_overrun); end
    endtask

    task automatic test_reset_mid_access;
        logic [37:0] obs;
        a_cpu_request = 1'b1; a_cpu_write = 1'b0; a_cpu_address = 10'h020;
        tick();
        a_reset = 1'b1;
        #1;
        obs = {a_video_data, a_video_valid, a_video_overrun, a_cpu_ready, a_cpu_read_data,
               a_memory_address, a_memory_write_enable, a_memory_write_data};
        n_cmp++;
        if (obs !== 38'h0) begin n_bad++; $display("FAIL midrst_outputs: got %h want 0", obs); end
        a_cpu_request = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (a_cpu_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_no_ready: got %b want 0", a_cpu_ready); end
        end
        a_reset = 1'b0;
        a_cpu_request = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_cmp++;
            if (a_cpu_ready !== (c == 3)) begin n_bad++; $display("FAIL midrst_reread_c%0d: got rdy=%b", c, a_cpu_ready); end
        end
        n_cmp++;
        if (a_cpu_read_data !== 8'h3C) begin n_bad++; $display("FAIL midrst_reread_data: got %h want 3c", a_cpu_read_data); end
        tick();
        a_cpu_request = 1'b0;
        // write abandoned by reset
        tick();
        a_cpu_request = 1'b1; a_cpu_write = 1'b1; a_cpu_address = 10'h100; a_cpu_write_data = 8'h55;
        tick();
        n_cmp++;
        if (a_memory_write_enable !== 1'b1) begin n_bad++; $display("FAIL midrst_we_c1: got %b want 1", a_memory_write_enable); end
        a_reset = 1'b1;
        #1;
        n_cmp++;
        if (a_memory_write_enable !== 1'b0) begin n_bad++; $display("FAIL midrst_we_drop: got %b want 0", a_memory_write_enable); end
        a_cpu_request = 1'b0; a_cpu_write = 1'b0;
        tick();
        a_reset = 1'b0;
        tick();
        n_cmp++;
        if ({a_cpu_ready, mem_a[10'h100]} !== {1'b0, 8'h00}) begin
            n_bad++; $display("FAIL midrst_no_write: got rdy=%b mem=%h want 0 00", a_cpu_ready, mem_a[10'h100]);
        end
    endtask

    task automatic test_latency3;
        logic [37:0] obs;
        b_cpu_request = 1'b1; b_cpu_write = 1'b0; b_cpu_address = 10'h020;
        tick();
        b_reset = 1'b1;
        #1;
        obs = {b_video_data, b_video_valid, b_video_overrun, b_cpu_ready, b_cpu_read_data,
               b_memory_address, b_memory_write_enable, b_memory_write_data};
        n_cmp++;
        if (obs !== 38'h0) begin n_bad++; $display("FAIL l3_midrst_outputs: got %h want 0", obs); end
        b_cpu_request = 1'b0;
        tick();
        n_cmp++;
        if (b_cpu_ready !== 1'b0) begin n_bad++; $display("FAIL l3_midrst_no_ready: got %b want 0", b_cpu_ready); end
        b_reset = 1'b0;
        b_cpu_request = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_cmp++;
            if (b_cpu_ready !== (c == 5)) begin n_bad++; $display("FAIL l3_ready_c%0d: got %b want %b", c, b_cpu_ready, (c == 5)); end
        end
        n_cmp++;
        if (b_cpu_read_data !== 8'h3C) begin n_bad++; $display("FAIL l3_data: got %h want 3c", b_cpu_read_data); end
        tick();
        b_cpu_request = 1'b0;
        n_cmp++;
        if (b_cpu_ready !== 1'b0) begin n_bad++; $display("FAIL l3_ready_c6: got %b want 0", b_cpu_ready); end
    endtask

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_video_request = 1'b0; a_video_address = '0; a_cpu_request = 1'b0; a_cpu_write = 1'b0;
        a_cpu_address = '0; a_cpu_write_data = '0;
        b_video_request = 1'b0; b_video_address = '0; b_cpu_request = 1'b0; b_cpu_write = 1'b0;
        b_cpu_address = '0; b_cpu_write_data = '0;
        tick();
        preload(10'h005, 8'h41);
        preload(10'h010, 8'hA5);
        preload(10'h020, 8'h3C);
        preload(10'h011, 8'h77);
        preload(10'h040, 8'h99);
        preload(10'h001, 8'h11);
        preload(10'h002, 8'h22);
        preload(10'h100, 8'h00);
        test_reset();
        test_video_fetch();
        tick();
        test_cpu_write();
        test_simultaneous();
        tick();
        test_pending();
        tick();
        test_overrun();
        test_reset_mid_access();
        test_latency3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
